// File: rtl/pixel_sensor_ctrl_pkg.sv
// Shared configuration for the pixel sensor: array geometry, sequencer defaults
// and the frame controller state encoding.
package PixelSensorConfig;

  localparam int unsigned PIXEL_ARRAY_HEIGHT = 4;
  localparam int unsigned PIXEL_ARRAY_WIDTH  = 4;
  localparam int unsigned PIXEL_BITS         = 8;
  localparam int unsigned ERASE_CYCLES       = 5;
  localparam int unsigned READ_ROW_CYCLES    = 5;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ,
    HOLD
  } ctrl_state_t;

endpackage

// File: rtl/pixel_sensor_ctrl_ramp.sv
// Ramp counter driving the in-pixel latches; registered output.
// PIXEL_CTRL_GRAY_RAMP_EN selects a Gray-coded ramp instead of plain binary.
module ramp_generator #(
  parameter int unsigned PIXEL_BITS = PixelSensorConfig::PIXEL_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  clear_i,
  output logic [PIXEL_BITS-1:0] ramp_o
);

  logic [PIXEL_BITS-1:0] cnt_q;
  logic [PIXEL_BITS-1:0] cnt_d;
  logic [PIXEL_BITS-1:0] code_d;

  // Clear wins so the ramp returns to zero on the last conversion cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + PIXEL_BITS'(1);
    end
  end

`ifdef PIXEL_CTRL_GRAY_RAMP_EN
  assign code_d = cnt_d ^ (cnt_d >> 1);
`else
  assign code_d = cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      ramp_o <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ramp_o <= code_d;
    end
  end

endmodule

// File: rtl/pixel_sensor_ctrl.sv
// Frame controller: erase, expose, ramp conversion and row readout with a
// valid/ready row stream. Ramp coding follows PIXEL_CTRL_GRAY_RAMP_EN.
module pixel_sensor_ctrl #(
  parameter int unsigned ROWS            = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
  parameter int unsigned COLS            = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
  parameter int unsigned PIXEL_BITS      = PixelSensorConfig::PIXEL_BITS,
  parameter int unsigned ERASE_CYCLES    = PixelSensorConfig::ERASE_CYCLES,
  parameter int unsigned READ_ROW_CYCLES = PixelSensorConfig::READ_ROW_CYCLES
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      continuous,
  input  logic [15:0]                               expose_cycles,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic                                      erase,
  output logic                                      expose,
  output logic                                      convert,
  output logic [ROWS-1:0]                           read,
  output logic [PIXEL_BITS-1:0]                     ramp_count,
  input  logic [COLS*PIXEL_BITS-1:0]                row_data,
  output logic [COLS*PIXEL_BITS-1:0]                out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                      out_valid,
  input  logic                                      out_ready
);

  import PixelSensorConfig::*;

  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W     = (PIXEL_BITS + 1 > 16) ? PIXEL_BITS + 1 : 16;
  localparam int unsigned CONV_LAST = (2 ** PIXEL_BITS) - 1;

  ctrl_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      expose_len_q;
  logic [ROW_W-1:0] row_q;

  logic             phase_end_c;
  logic [15:0]      expose_latch_c;
  logic             ramp_en_c;
  logic             ramp_clr_c;

  // Zero exposure is promoted to a single cycle.
  assign expose_latch_c = (expose_cycles == 16'd0) ? 16'd1 : expose_cycles;

  // High in the final cycle of each timed phase.
  always_comb begin
    phase_end_c = 1'b0;
    case (state_q)
      ERASE:   phase_end_c = (cnt_q == CNT_W'(ERASE_CYCLES - 1));
      EXPOSE:  phase_end_c = (cnt_q == CNT_W'(expose_len_q - 16'd1));
      CONVERT: phase_end_c = (cnt_q == CNT_W'(CONV_LAST));
      READ:    phase_end_c = (cnt_q == CNT_W'(READ_ROW_CYCLES - 1));
      default: phase_end_c = 1'b0;
    endcase
  end

  assign ramp_en_c  = (state_q == CONVERT);
  assign ramp_clr_c = (state_q == CONVERT) && phase_end_c;

  ramp_generator #(
    .PIXEL_BITS(PIXEL_BITS)
  ) u_ramp (
    .clk      (clk),
    .reset    (reset),
    .enable_i (ramp_en_c),
    .clear_i  (ramp_clr_c),
    .ramp_o   (ramp_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      expose_len_q <= 16'd1;
      row_q        <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      erase        <= 1'b0;
      expose       <= 1'b0;
      convert      <= 1'b0;
      read         <= '0;
      out_data     <= '0;
      out_row      <= '0;
      out_valid    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= ERASE;
            busy         <= 1'b1;
            erase        <= 1'b1;
            cnt_q        <= '0;
            expose_len_q <= expose_latch_c;
          end
        end
        ERASE: begin
          if (phase_end_c) begin
            state_q <= EXPOSE;
            erase   <= 1'b0;
            expose  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        EXPOSE: begin
          if (phase_end_c) begin
            state_q <= CONVERT;
            expose  <= 1'b0;
            convert <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CONVERT: begin
          if (phase_end_c) begin
            state_q <= READ;
            convert <= 1'b0;
            read    <= ROWS'(1);
            row_q   <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        READ: begin
          if (phase_end_c) begin
            state_q   <= HOLD;
            read      <= '0;
            out_data  <= row_data;
            out_row   <= row_q;
            out_valid <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt_q     <= '0;
            if (row_q == ROW_W'(ROWS - 1)) begin
              frame_done <= 1'b1;
              if (continuous) begin
                state_q      <= ERASE;
                erase        <= 1'b1;
                expose_len_q <= expose_latch_c;
              end else begin
                state_q <= IDLE;
                busy    <= 1'b0;
              end
            end else begin
              state_q <= READ;
              row_q   <= row_q + ROW_W'(1);
              read    <= ROWS'(1) << (row_q + ROW_W'(1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Self-checking bench for pixel_sensor_ctrl: cycle-accurate timing model plus a
// scoreboard of captured rows. Ramp expectation follows PIXEL_CTRL_GRAY_RAMP_EN.
module tb_pixel_sensor_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        continuous;
  logic [15:0] expose_cycles;
  logic        busy;
  logic        frame_done;
  logic        erase;
  logic        expose;
  logic        convert;
  logic [1:0]  read;
  logic [7:0]  ramp_count;
  logic [31:0] row_data;
  logic [31:0] out_data;
  logic [0:0]  out_row;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0]  salt = 8'd0;
  logic [32:0] sb_q[$];
  logic [15:0] obs;

  always #5 clk = ~clk;

  pixel_sensor_ctrl #(
    .ROWS(2), .COLS(4), .PIXEL_BITS(8), .ERASE_CYCLES(5), .READ_ROW_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .expose_cycles(expose_cycles), .busy(busy), .frame_done(frame_done),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .ramp_count(ramp_count), .row_data(row_data), .out_data(out_data),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready)
  );

  assign obs = {busy, frame_done, erase, expose, convert, read, ramp_count, out_valid};

  function automatic logic [31:0] pat(logic [7:0] s, int row);
    return {s, 8'(row), 8'hA5 ^ s, 8'(row * 3 + 1)};
  endfunction

  // Pixel array model: data is only meaningful while a single row is selected.
  always_comb begin
    row_data = 32'hDEAD_BEEF;
    if (read == 2'b01) row_data = pat(salt, 0);
    else if (read == 2'b10) row_data = pat(salt, 1);
  end

  function automatic logic [7:0] enc(logic [7:0] b);
`ifdef PIXEL_CTRL_GRAY_RAMP_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Expected output vector at cycle k of a frame started at cycle 0 with
  // exposure e and d stall cycles on row 0's handshake.
  function automatic logic [15:0] model(int k, int e, int d);
    int cs, r0, v0, h0, r1, v1, fd;
    logic [7:0] rc;
    logic [1:0] rd;
    cs = 6 + e; r0 = cs + 256; v0 = r0 + 5; h0 = v0 + d;
    r1 = h0 + 1; v1 = r1 + 5; fd = v1 + 1;
    rc = 8'd0;
    if (k >= cs && k < r0) rc = enc(8'(k - cs));
    rd = 2'b00;
    if (k >= r0 && k < r0 + 5) rd = 2'b01;
    else if (k >= r1 && k < r1 + 5) rd = 2'b10;
    return {(k >= 1 && k <= v1), (k == fd), (k >= 1 && k <= 5), (k >= 6 && k < cs),
            (k >= cs && k < r0), rd, rc, ((k >= v0 && k <= h0) || k == v1)};
  endfunction

  // Advance one cycle; a handshake in the current cycle retires a scoreboard entry.
  task automatic step();
    logic [32:0] e;
    if (out_valid && out_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected cyc=%0d got row=%0d data=%h", cyc, out_row, out_data);
      end else begin
        e = sb_q.pop_front();
        if ({out_row, out_data} !== e) begin
          bad++;
          $display("FAIL sb_row cyc=%0d got=%h exp=%h", cyc, {out_row, out_data}, e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_frame();
    sb_q.push_back({1'b0, pat(salt, 0)});
    sb_q.push_back({1'b1, pat(salt, 1)});
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; continuous = 1'b0; expose_cycles = 16'd10; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 16'd0 || out_data !== 32'd0 || out_row !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got=%h data=%h row=%0d exp=0", obs, out_data, out_row);
    end
    reset = 1'b0;
    step();
    total++;
    if (obs !== 16'd0) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=0", obs);
    end
  endtask

  task automatic test_single();
    logic [15:0] exp;
    salt = 8'h11; cyc = 0; expose_cycles = 16'd10; push_frame(); start = 1'b1;
    for (int i = 0; i < 290; i++) begin
      step();
      start = 1'b0;
      exp = model(cyc, 10, 0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL single_rows_left got=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    salt = 8'h22; cyc = 0; expose_cycles = 16'd10; push_frame(); start = 1'b1;
    for (int i = 0; i < 310; i++) begin
      out_ready = !(cyc >= 277 && cyc <= 299);
      step();
      start = 1'b0;
      exp = model(cyc, 10, 23);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      if (cyc >= 277 && cyc <= 300) begin
        total++;
        if (out_data !== pat(salt, 0) || out_row !== 1'b0) begin
          bad++;
          $display("FAIL hold_stable cyc=%0d got=%h row=%0d exp=%h row=0",
                   cyc, out_data, out_row, pat(salt, 0));
        end
      end
    end
    out_ready = 1'b1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL bp_rows_left got=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_continuous();
    logic [15:0] exp;
    salt = 8'h33; cyc = 0; expose_cycles = 16'd10; continuous = 1'b1;
    push_frame(); push_frame(); start = 1'b1;
    for (int i = 0; i < 570; i++) begin
      step();
      start = 1'b0;
      if (cyc == 20) expose_cycles = 16'd3;
      if (cyc == 300) continuous = 1'b0;
      if (cyc < 284) begin
        exp = model(cyc, 10, 0);
      end else begin
        exp = model(cyc - 283, 3, 0);
        if (cyc == 284) exp[14] = 1'b1;
      end
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL continuous cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL cont_rows_left got=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] exp;
    salt = 8'h44; cyc = 0; expose_cycles = 16'd10; push_frame(); start = 1'b1;
    for (int i = 0; i < 150; i++) begin
      step();
      start = 1'b0;
      exp = model(cyc, 10, 0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
    end
    reset = 1'b1;
    step();
    total++;
    if (obs !== 16'd0 || out_data !== 32'd0 || out_row !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset cyc=%0d got=%h data=%h exp=0", cyc, obs, out_data);
    end
    reset = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs !== 16'd0) begin
        bad++;
        $display("FAIL post_reset_idle cyc=%0d got=%h exp=0", cyc, obs);
      end
    end
    salt = 8'h45; cyc = 0; push_frame(); start = 1'b1;
    for (int i = 0; i < 288; i++) begin
      step();
      start = 1'b0;
      exp = model(cyc, 10, 0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rerun cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_zero_expose();
    logic [15:0] exp;
    int n_exp;
    salt = 8'h55; cyc = 0; expose_cycles = 16'd0; push_frame(); start = 1'b1; n_exp = 0;
    for (int i = 0; i < 280; i++) begin
      step();
      start = 1'b0;
      if (expose) n_exp++;
      exp = model(cyc, 1, 0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL zero_expose cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
    end
    total++;
    if (n_exp != 1) begin
      bad++;
      $display("FAIL zero_expose_len got=%0d exp=1", n_exp);
    end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] exp;
    int n_done;
    salt = 8'h66; cyc = 0; expose_cycles = 16'd10; push_frame(); start = 1'b1; n_done = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      start = (cyc == 3 || cyc == 50 || cyc == 200 || cyc == 277 || cyc == 283);
      if (frame_done) n_done++;
      exp = model(cyc, 10, 0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL start_busy cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
    end
    start = 1'b0;
    total++;
    if (n_done != 1 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL start_busy_done got=%0d rows_left=%0d exp=1,0", n_done, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_continuous();
    test_reset_mid_frame();
    test_zero_expose();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
